// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: FSM sequencing the shared datapath with a memory-ready handshake and stall abort.
// Optional ADDI support is enabled by defining ADDI_EN.
module multicycle_control #(
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Inst,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
        MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
        RWB    = 4'd8,  BRANCH = 4'd9,  JUMP   = 4'd10, ADDIEX = 4'd11,
        ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif
    // Counter value at which one more stalled cycle exhausts the budget.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            cur, nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              is_sw, is_sw_nxt;
    logic              ill_set;
    logic              expired;

    assign state   = cur;
    assign expired = (wait_cnt == WAIT_LAST) && !mem_ready;

    // State, wait counter, held lw/sw selector and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= IDLE;
            wait_cnt   <= '0;
            is_sw      <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            cur      <= nxt;
            wait_cnt <= wait_nxt;
            is_sw    <= is_sw_nxt;
            if (ill_set) illegal_op <= 1'b1;
        end
    end

    // Next state and control decode.
    always_comb begin
        nxt         = cur;
        wait_nxt    = '0;
        is_sw_nxt   = is_sw;
        ill_set     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        mem_timeout = 1'b0;

        // Only memory states count stalls; any completion or abort clears the counter.
        if ((cur == FETCH || cur == MEMRD || cur == MEMWR) && !mem_ready && !expired)
            wait_nxt = wait_cnt + WAIT_W'(1);

        case (cur)
            IDLE: nxt = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = DECODE;
                end else if (expired) begin
                    mem_timeout = 1'b1;
                end
            end
            DECODE: begin
                ALUSrcB   = 2'b11;
                is_sw_nxt = (Inst == OP_SW);
                case (Inst)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
                    OP_J:         nxt = JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      nxt = ADDIEX;
`endif
                    default: begin
                        ill_set = 1'b1;
                        nxt     = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = is_sw ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    nxt = MEMWB;
                end else if (expired) begin
                    mem_timeout = 1'b1;
                    nxt         = FETCH;
                end
            end
            MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end else if (expired) begin
                    mem_timeout = 1'b1;
                    nxt         = FETCH;
                end
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                nxt     = RWB;
            end
            RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                nxt         = FETCH;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
`ifdef ADDI_EN
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = ADDIWB;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
`endif
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control words queued as stimulus is driven.
// Build with ADDI_EN defined to exercise the ADDI path instead of the illegal-opcode path.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] inst;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       instr_done, illegal_op, mem_timeout;
    logic [3:0] state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        ill_m    = 1'b0;
    logic [22:0] exp_q[$];

    multicycle_control #(.WAIT_W(4), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .Inst(inst), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference control word per state, written from the controller's output table.
    function automatic logic [22:0] exp_vec(input logic [3:0] es, input logic rdy,
                                            input logic dn, input logic tmo, input logic ill);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca} = '0;
        {srcb, aluop, pcsrc} = '0;
        case (es)
            4'd1:  begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            4'd2:  srcb = 2'b11;
            4'd3:  begin srca = 1; srcb = 2'b10; end
            4'd4:  begin mr = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mw = 1; iord = 1; end
            4'd7:  begin srca = 1; aluop = 2'b10; end
            4'd8:  begin rw = 1; rdst = 1; end
            4'd9:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
            4'd10: begin pcw = 1; pcsrc = 2'b10; end
            4'd11: begin srca = 1; srcb = 2'b10; end
            4'd12: rw = 1;
            default: ;
        endcase
        return {es, pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca,
                srcb, aluop, pcsrc, dn, tmo, ill};
    endfunction

    function automatic logic [22:0] observed();
        return {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                instr_done, mem_timeout, illegal_op};
    endfunction

    task automatic compare_next(input string tag);
        logic [22:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_empty_q"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, 32'(observed()), 32'(e));
        end
    endtask

    // One clock: drive at negedge, queue expectation, compare once outputs settle.
    task automatic step(input logic rdy, input logic [5:0] op, input logic [3:0] es,
                        input logic dn, input logic tmo, input string tag);
        @(negedge clk);
        mem_ready = rdy;
        inst      = op;
        exp_q.push_back(exp_vec(es, rdy, dn, tmo, ill_m));
        #1;
        compare_next(tag);
    endtask

    task automatic fd(input logic [5:0] op, input string tag);
        step(1'b1, op, 4'd1, 1'b0, 1'b0, {tag, "_fetch"});
        step(1'b0, op, 4'd2, 1'b0, 1'b0, {tag, "_decode"});
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        #1;
        check_eq("rel_idle", 32'(state), 32'd0);
        step(1'b1, 6'b000000, 4'd1, 1'b0, 1'b0, "rel_fetch");
        step(1'b0, 6'b000000, 4'd2, 1'b0, 1'b0, "rel_decode");
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; inst = 6'b000000;
        repeat (3) step(1'b1, 6'b000000, 4'd0, 1'b0, 1'b0, "reset_idle");

        // R-type: fetch/decode after release, then EXEC and RWB.
        release_reset();
        step(1'b1, 6'b000000, 4'd7, 1'b0, 1'b0, "r_exec");
        step(1'b0, 6'b000000, 4'd8, 1'b1, 1'b0, "r_rwb");

        // Stalled fetch, then beq.
        step(1'b0, 6'b000100, 4'd1, 1'b0, 1'b0, "f_stall0");
        step(1'b0, 6'b000100, 4'd1, 1'b0, 1'b0, "f_stall1");
        step(1'b1, 6'b000100, 4'd1, 1'b0, 1'b0, "f_ready");
        step(1'b1, 6'b000100, 4'd2, 1'b0, 1'b0, "beq_decode");
        step(1'b0, 6'b000100, 4'd9, 1'b1, 1'b0, "beq_branch");

        fd(6'b000010, "j");
        step(1'b1, 6'b000010, 4'd10, 1'b1, 1'b0, "j_jump");

        // lw with three stalled MEMRD cycles.
        fd(6'b100011, "lw");
        step(1'b1, 6'b111111, 4'd3, 1'b0, 1'b0, "lw_memadr");
        repeat (3) step(1'b0, 6'b111111, 4'd4, 1'b0, 1'b0, "lw_memrd_stall");
        step(1'b1, 6'b111111, 4'd4, 1'b0, 1'b0, "lw_memrd_ready");
        step(1'b0, 6'b111111, 4'd5, 1'b1, 1'b0, "lw_memwb");

        fd(6'b101011, "sw");
        step(1'b0, 6'b101011, 4'd3, 1'b0, 1'b0, "sw_memadr");
        step(1'b1, 6'b101011, 4'd6, 1'b1, 1'b0, "sw_memwr");

        // Ready on the last tolerated cycle: completion wins over timeout.
        fd(6'b100011, "lwb");
        step(1'b0, 6'b100011, 4'd3, 1'b0, 1'b0, "lwb_memadr");
        repeat (14) step(1'b0, 6'b100011, 4'd4, 1'b0, 1'b0, "lwb_stall");
        step(1'b1, 6'b100011, 4'd4, 1'b0, 1'b0, "lwb_ready_at_limit");
        step(1'b0, 6'b100011, 4'd5, 1'b1, 1'b0, "lwb_memwb");

        // sw that never completes: abort on 15th MEMWR cycle.
        fd(6'b101011, "swt");
        step(1'b0, 6'b101011, 4'd3, 1'b0, 1'b0, "swt_memadr");
        repeat (14) step(1'b0, 6'b101011, 4'd6, 1'b0, 1'b0, "swt_stall");
        step(1'b0, 6'b101011, 4'd6, 1'b0, 1'b1, "swt_timeout");
        step(1'b0, 6'b101011, 4'd1, 1'b0, 1'b0, "swt_refetch_stall");

`ifdef ADDI_EN
        fd(6'b001000, "addi");
        step(1'b0, 6'b001000, 4'd11, 1'b0, 1'b0, "addi_ex");
        step(1'b0, 6'b001000, 4'd12, 1'b1, 1'b0, "addi_wb");
`else
        fd(6'b001000, "addi_ill");
        ill_m = 1'b1;
`endif
        fd(6'b111111, "ill");
        ill_m = 1'b1;
        step(1'b0, 6'b000000, 4'd1, 1'b0, 1'b0, "ill_sticky_fetch");
        step(1'b1, 6'b000000, 4'd1, 1'b0, 1'b0, "ill_sticky_fetch_rdy");
        step(1'b0, 6'b000000, 4'd2, 1'b0, 1'b0, "ill_sticky_decode");
        step(1'b0, 6'b000000, 4'd7, 1'b0, 1'b0, "ill_sticky_exec");

        // Reset mid-instruction: outputs and sticky flag clear immediately.
        rst_n = 1'b0;
        ill_m = 1'b0;
        #1;
        exp_q.push_back(exp_vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        compare_next("midrst_async");
        step(1'b1, 6'b000000, 4'd0, 1'b0, 1'b0, "midrst_hold");
        release_reset();
        step(1'b0, 6'b000000, 4'd7, 1'b0, 1'b0, "post_exec");
        step(1'b0, 6'b000000, 4'd8, 1'b1, 1'b0, "post_rwb");

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
